// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit that owns the HI/LO registers.
// Operands are converted to magnitudes at issue. One bit is processed per cycle
// (shift-add for multiply, restoring division for divide). Sign fixups are
// applied in a final cycle that also writes HI/LO.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int            CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_SIGN = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Operation context captured at issue
   logic             is_div_q;
   logic             div0_q;
   logic             sign_a_q;
   logic             sign_b_q;
   logic [WIDTH-1:0] opnd_q;     // multiplicand (MUL) or divisor (DIV)
   logic [2*WIDTH-1:0] acc_q;    // {upper product | remainder, multiplier | quotient}
   logic [CW-1:0]    count_q;

   // Architectural registers and status
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             done_q, dbz_q;

   // Issue-time operand preparation
   logic             op_signed;
   logic             sign_a_in, sign_b_in;
   logic [WIDTH-1:0] mag_a, mag_b;

   // Per-cycle step
   logic [WIDTH-1:0]   mul_add;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] acc_step;

   // Sign fixups
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;
   logic [WIDTH-1:0]   res_hi, res_lo;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, regardless of statement order.
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: IDLE -> CALC (WIDTH cycles) -> SIGN -> IDLE
   always_comb begin
      // NOTE: a default assignment first keeps every path driven, so no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_CALC;
         S_CALC:  if (count_q == LAST) state_d = S_SIGN;
         S_SIGN:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: busy is decoded from the state register only
   always_comb begin
      busy = (state_q != S_IDLE);
   end

   // Operand magnitudes and signs; unsigned ops pass through unchanged
   always_comb begin
      op_signed = ~op[0];
      sign_a_in = op_signed & src_a[WIDTH-1];
      sign_b_in = op_signed & src_b[WIDTH-1];
      mag_a     = sign_a_in ? -src_a : src_a;
      mag_b     = sign_b_in ? -src_b : src_b;
   end

   // One iteration: shift-add multiply or restoring-division step
   always_comb begin
      mul_add   = acc_q[0] ? opnd_q : '0;
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
      div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_ge    = (div_trial >= {1'b0, opnd_q});
      // The trial is below twice the divisor, so a WIDTH-bit difference is exact
      div_rem   = div_ge ? (div_trial[WIDTH-1:0] - opnd_q) : div_trial[WIDTH-1:0];
      if (is_div_q) acc_step = {div_rem, acc_q[WIDTH-2:0], div_ge};
      else          acc_step = {mul_sum, acc_q[WIDTH-1:1]};
   end

   // Sign fixups and final HI/LO selection
   always_comb begin
      prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
      quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      // Remainder follows the dividend; with a zero divisor it equals src_a
      rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      if (is_div_q) begin
         res_hi = rem_fix;
         res_lo = div0_q ? '1 : quot_fix;
      end else begin
         res_hi = prod_fix[2*WIDTH-1:WIDTH];
         res_lo = prod_fix[WIDTH-1:0];
      end
   end

   // Datapath: issue capture, iteration, result write-back and MTHI/MTLO
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         is_div_q <= 1'b0;
         div0_q   <= 1'b0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         count_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  is_div_q <= op[1];
                  div0_q   <= op[1] & (src_b == '0);
                  sign_a_q <= sign_a_in;
                  sign_b_q <= sign_b_in;
                  opnd_q   <= op[1] ? mag_b : mag_a;
                  acc_q    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                  count_q  <= '0;
               end else begin
                  if (hi_we) hi_q <= wdata;
                  if (lo_we) lo_q <= wdata;
               end
            end
            S_CALC: begin
               acc_q   <= acc_step;
               count_q <= count_q + CW'(1);
            end
            S_SIGN: begin
               hi_q   <= res_hi;
               lo_q   <= res_lo;
               done_q <= 1'b1;
               dbz_q  <= div0_q;
            end
            default: ;
         endcase
      end
   end

   assign hi          = hi_q;
   assign lo          = lo_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, MTHI/MTLO and
// priority rules, mid-operation reset, then random ops against a 64-bit
// arithmetic reference model.
module tb_muldiv_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] src_a, src_b, wdata;
   logic         hi_we, lo_we;
   logic         busy, done, div_by_zero;
   logic [W-1:0] hi, lo;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .op          (op),
      .src_a       (src_a),
      .src_b       (src_b),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: plain 64-bit integer arithmetic (SV division truncates
   // toward zero and the remainder takes the dividend's sign)
   task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = o[0] ? longint'({32'b0, a}) : longint'($signed(a));
      sb = o[0] ? longint'({32'b0, b}) : longint'($signed(b));
      ed = 1'b0;
      if (!o[1]) begin
         p  = o[0] ? ({32'b0, a} * {32'b0, b}) : 64'(sa * sb);
         eh = p[63:32];
         el = p[31:0];
      end else if (b == 0) begin
         eh = a;
         el = '1;
         ed = 1'b1;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         eh = r[31:0];
         el = q[31:0];
      end
   endtask

   // Issue at the next edge; returns at the negedge just after acceptance
   task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(negedge clk);
      start = 1'b0; src_a = $urandom(); src_b = $urandom();
   endtask

   // Count remaining busy cycles (bounded), then check the result and done pulse
   task automatic wait_result(input string tag, input int pre, input logic [W-1:0] eh,
                              input logic [W-1:0] el, input logic ed);
      int n;
      n = pre;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      check({tag, " busy_cycles"}, 64'(n), 64'(W + 1));
      check({tag, " done"}, 64'(done), 64'd1);
      check({tag, " hi"}, 64'(hi), 64'(eh));
      check({tag, " lo"}, 64'(lo), 64'(el));
      check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(ed));
      @(negedge clk);
      check({tag, " done_drop"}, 64'(done), 64'd0);
      check({tag, " hi_hold"}, 64'(hi), 64'(eh));
   endtask

   task automatic run_model(input string tag, input logic [1:0] o,
                            input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] eh, el;
      logic         ed;
      model(o, a, b, eh, el, ed);
      issue(o, a, b);
      wait_result(tag, 0, eh, el, ed);
   endtask

   function automatic logic [W-1:0] pick_operand();
      logic [W-1:0] edges [6];
      edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
      if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
      if ($urandom_range(0, 2) == 0) return W'($urandom_range(0, 50));
      return $urandom();
   endfunction

   initial begin
      logic seen_done;
      rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst busy", 64'(busy), 64'd0);
      check("rst done", 64'(done), 64'd0);
      check("rst dbz", 64'(div_by_zero), 64'd0);
      check("rst hi", 64'(hi), 64'd0);
      check("rst lo", 64'(lo), 64'd0);
      rst = 1'b0;

      // Directed corner cases with hand-computed results
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_result("multu_max", 0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      issue(2'b00, 32'hFFFF_FFFD, 32'd7);
      wait_result("mult_neg3x7", 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      issue(2'b00, 32'h8000_0000, 32'h8000_0000);
      wait_result("mult_min_sq", 0, 32'h4000_0000, 32'h0, 1'b0);
      issue(2'b10, 32'hFFFF_FFF9, 32'd2);
      wait_result("div_neg7_2", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      issue(2'b11, 32'd100, 32'd7);
      wait_result("divu_100_7", 0, 32'd2, 32'd14, 1'b0);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_result("div_min_neg1", 0, 32'h0, 32'h8000_0000, 1'b0);
      issue(2'b11, 32'd5, 32'd0);
      wait_result("divu_by_zero", 0, 32'd5, 32'hFFFF_FFFF, 1'b1);
      issue(2'b10, 32'hFFFF_FFF9, 32'd0);
      wait_result("div_neg_by_zero", 0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

      // MTHI and MTLO together
      @(negedge clk);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      check("mt_both hi", 64'(hi), 64'hCAFE_F00D);
      check("mt_both lo", 64'(lo), 64'hCAFE_F00D);

      // Second start and MTHI during busy are ignored
      issue(2'b01, 32'd1000, 32'd3000);
      repeat (4) @(negedge clk);
      start = 1'b1; op = 2'b11; src_a = 32'd9; src_b = 32'd2;
      hi_we = 1'b1; wdata = 32'hAAAA_5555;
      @(negedge clk);
      start = 1'b0; hi_we = 1'b0;
      wait_result("ignore_busy", 5, 32'd0, 32'd3_000_000, 1'b0);

      // Asynchronous reset in the middle of a divide
      issue(2'b10, 32'd12345, 32'd17);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst busy", 64'(busy), 64'd0);
      check("midrst hi", 64'(hi), 64'd0);
      check("midrst lo", 64'(lo), 64'd0);
      check("midrst done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      seen_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) seen_done = 1'b1;
      end
      check("midrst no_done", 64'(seen_done), 64'd0);
      check("midrst lo_after", 64'(lo), 64'd0);

      // MTLO alone, then start wins over lo_we in the same cycle
      @(negedge clk);
      lo_we = 1'b1; wdata = 32'h1234;
      @(negedge clk);
      lo_we = 1'b0;
      check("mtlo lo", 64'(lo), 64'h1234);
      check("mtlo hi", 64'(hi), 64'd0);
      @(negedge clk);
      start = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd5;
      lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0; lo_we = 1'b0;
      check("start_prio lo_early", 64'(lo), 64'h1234);
      wait_result("start_prio", 0, 32'd0, 32'd15, 1'b0);

      // Random operations against the reference model
      for (int i = 0; i < 24; i++) begin
         logic [1:0]   ro;
         logic [W-1:0] ra, rb;
         ro = 2'($urandom_range(0, 3));
         ra = pick_operand();
         rb = pick_operand();
         run_model($sformatf("rand%0d op%0d %h/%h", i, ro, ra, rb), ro, ra, rb);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
